// File: rtl/joybus_device.sv
// JOYBUS responder: decodes 8-bit host commands and replies with DEV_ID or the status word.
// Optional JOYBUS_RESET_CMD_EN: command 0xFF also gets the identity reply and flushes the latched reply.
module joybus_device #(
  parameter int          CLK_PER_US   = 25,
  parameter int          TIMEOUT_US   = 8,
  parameter int          REPLY_GAP_US = 2,
  parameter logic [23:0] DEV_ID       = 24'h050002
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire         JB,
  input  logic [31:0] status,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  output logic        busy,
  output logic        tx_active
);

  localparam int CELL    = 4 * CLK_PER_US;
  localparam int TMO     = TIMEOUT_US * CLK_PER_US;
  localparam int CNT_MAX = (TMO > CELL) ? TMO : CELL;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CELL_END  = CW'(CELL - 1);
  localparam logic [CW-1:0] SAMPLE_PT = CW'(2 * CLK_PER_US - 1);
  localparam logic [CW-1:0] TMO_END   = CW'(TMO - 1);
  // Three cycles of the gap are already spent in the synchronizer and the state/drive registers.
  localparam logic [CW-1:0] GAP_END   = CW'(REPLY_GAP_US * CLK_PER_US - 4);
  localparam logic [CW-1:0] ONE_LOW   = CW'(CLK_PER_US);
  localparam logic [CW-1:0] ZERO_LOW  = CW'(3 * CLK_PER_US);
  localparam logic [CW-1:0] STOP_LOW  = CW'(2 * CLK_PER_US);
  localparam logic [CW-1:0] STOP_END  = CW'(3 * CLK_PER_US - 1);

  typedef enum logic [2:0] {
    IDLE,
    RX_BIT,
    RX_WAIT,
    RX_STOP,
    GAP,
    TX_BIT,
    TX_STOP
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [5:0]    bit_cnt, bit_cnt_d;
  logic [5:0]    reply_last, reply_last_d;
  logic [7:0]    rx_sr, rx_sr_d;
  logic [31:0]   reply_sr, reply_sr_d;
  logic [7:0]    cmd_d;
  logic          cmd_valid_d;
  logic          drive, drive_d;
  logic          sync1, sync2, sync_d;
  logic          fall;
`ifdef JOYBUS_RESET_CMD_EN
  logic          reset_pulse, reset_pulse_d;
`endif

  assign JB        = drive ? 1'b0 : 1'bz;
  assign busy      = (state != IDLE);
  assign tx_active = (state == TX_BIT) || (state == TX_STOP);
  // Our own drive must never look like a host edge.
  assign fall      = sync_d & ~sync2 & ~tx_active;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt + 1'b1;
    bit_cnt_d    = bit_cnt;
    reply_last_d = reply_last;
    rx_sr_d      = rx_sr;
    reply_sr_d   = reply_sr;
    cmd_d        = cmd;
    cmd_valid_d  = 1'b0;
`ifdef JOYBUS_RESET_CMD_EN
    reset_pulse_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d   = RX_BIT;
          bit_cnt_d = '0;
        end
      end
      RX_BIT: begin
        if (cnt == SAMPLE_PT) begin
          rx_sr_d   = {rx_sr[6:0], sync2};
          bit_cnt_d = bit_cnt + 1'b1;
          cnt_d     = '0;
          state_d   = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = (bit_cnt == 6'd8) ? RX_STOP : RX_BIT;
        end else if (cnt == TMO_END) begin
          state_d = IDLE;
        end
      end
      RX_STOP: begin
        if (sync2) begin
          cmd_d       = rx_sr;
          cmd_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
          case (rx_sr)
            8'h01: begin
              reply_sr_d   = status;
              reply_last_d = 6'd31;
              state_d      = GAP;
            end
            8'h00: begin
              reply_sr_d   = {DEV_ID, 8'h00};
              reply_last_d = 6'd23;
              state_d      = GAP;
            end
`ifdef JOYBUS_RESET_CMD_EN
            8'hFF: begin
              reply_sr_d    = '0;
              reply_last_d  = 6'd23;
              reset_pulse_d = 1'b1;
              state_d       = GAP;
            end
`endif
            default: ;
          endcase
        end else if (cnt == TMO_END) begin
          state_d = IDLE;
        end
      end
      GAP: begin
`ifdef JOYBUS_RESET_CMD_EN
        // The flushed reply register is refilled with the identity word.
        if (reset_pulse) reply_sr_d = {DEV_ID, 8'h00};
`endif
        if (cnt == GAP_END) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = TX_BIT;
        end
      end
      TX_BIT: begin
        if (cnt == CELL_END) begin
          cnt_d      = '0;
          reply_sr_d = {reply_sr[30:0], 1'b0};
          bit_cnt_d  = bit_cnt + 1'b1;
          if (bit_cnt == reply_last) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (cnt == STOP_END) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    drive_d = ((state_d == TX_BIT) && (cnt_d < (reply_sr_d[31] ? ONE_LOW : ZERO_LOW))) ||
              ((state_d == TX_STOP) && (cnt_d < STOP_LOW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      sync_d     <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      reply_last <= '0;
      rx_sr      <= '0;
      reply_sr   <= '0;
      cmd        <= '0;
      cmd_valid  <= 1'b0;
      drive      <= 1'b0;
`ifdef JOYBUS_RESET_CMD_EN
      reset_pulse <= 1'b0;
`endif
    end else begin
      sync1      <= JB;
      sync2      <= sync1;
      sync_d     <= sync2;
      state      <= state_d;
      cnt        <= cnt_d;
      bit_cnt    <= bit_cnt_d;
      reply_last <= reply_last_d;
      rx_sr      <= rx_sr_d;
      reply_sr   <= reply_sr_d;
      cmd        <= cmd_d;
      cmd_valid  <= cmd_valid_d;
      drive      <= drive_d;
`ifdef JOYBUS_RESET_CMD_EN
      reset_pulse <= reset_pulse_d;
`endif
    end
  end

endmodule

// File: tb/tb_joybus_device.sv
// Bench for joybus_device: emulated host on an open-drain line, table vectors, random polls and corner sequences.
`timescale 1ns/1ps
module tb_joybus_device;
  localparam int C = 25;

  typedef struct {
    logic [7:0]  c;
    logic [31:0] st;
    logic        has;
    int          len;
    logic [31:0] w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] status;
  logic [7:0]  cmd;
  logic        cmd_valid, busy, tx_active;
  logic        host_drv;
  wire         JB;

  assign JB = host_drv ? 1'b0 : 1'bz;
  pullup (JB);

  always #20 clk = ~clk;

  joybus_device dut (
    .clk(clk), .rst_n(rst_n), .JB(JB), .status(status),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .tx_active(tx_active)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         vld_cnt  = 0;
  int         vld_long = 0;
  int         dev_low  = 0;
  logic       prev_vld = 1'b0;
  logic [7:0] last_cmd = 8'h00;

  // Monitor sampled mid-cycle, clear of both clock edges.
  always @(posedge clk) begin
    #10;
    prev_vld <= cmd_valid;
    if (cmd_valid) begin
      vld_cnt  <= vld_cnt + 1;
      last_cmd <= cmd;
      if (prev_vld) vld_long <= vld_long + 1;
    end
    if (JB === 1'b0 && !host_drv) dev_low <= dev_low + 1;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Reference: which commands get a reply, and what it is.
  function automatic void model(input logic [7:0] c, input logic [31:0] st,
                                output logic has, output int len, output logic [31:0] w);
    has = 1'b0; len = 0; w = 32'h0;
    if (c == 8'h01) begin
      has = 1'b1; len = 32; w = st;
    end else if (c == 8'h00) begin
      has = 1'b1; len = 24; w = 32'h0005_0002;
    end
`ifdef JOYBUS_RESET_CMD_EN
    else if (c == 8'hFF) begin
      has = 1'b1; len = 24; w = 32'h0005_0002;
    end
`endif
  endfunction

  // Starts and ends on a negedge; each bit cell is 4 us.
  task automatic host_bits(input logic [7:0] c, input int nb);
    int lo;
    for (int i = 7; i > 7 - nb; i--) begin
      lo = c[i] ? C : 3 * C;
      host_drv = 1'b1;
      repeat (lo) @(negedge clk);
      host_drv = 1'b0;
      repeat (4 * C - lo) @(negedge clk);
    end
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk);
    host_bits(c, 8);
    host_drv = 1'b1;
    repeat (C) @(negedge clk);
    host_drv = 1'b0;
  endtask

  task automatic capture(input int len, output logic [31:0] w, output int gap,
                         output int stop_l, output int terr);
    int l, h;
    w = 32'h0; gap = 0; stop_l = 0; terr = 0;
    #1;
    while (JB !== 1'b0 && gap < 300) begin @(negedge clk); gap++; end
    if (gap >= 300) begin terr = 1000; return; end
    for (int i = 0; i < len; i++) begin
      l = 0;
      while (JB === 1'b0 && l < 200) begin @(negedge clk); l++; end
      h = 0;
      while (JB !== 1'b0 && h < 200) begin @(negedge clk); h++; end
      w = {w[30:0], (l < 2 * C)};
      if (!((l >= C - 2 && l <= C + 2) || (l >= 3 * C - 2 && l <= 3 * C + 2)) ||
          (l + h < 4 * C - 2) || (l + h > 4 * C + 2)) terr++;
    end
    l = 0;
    while (JB === 1'b0 && l < 200) begin @(negedge clk); l++; end
    stop_l = l;
  endtask

  task automatic do_txn(input string nm, input logic [7:0] c, input logic [31:0] st,
                        input logic has, input int len, input logic [31:0] ew, input int chg);
    logic [31:0] w;
    int gap, sl, terr, v0, d0, k;
    status = st;
    v0 = vld_cnt;
    d0 = dev_low;
    send_cmd(c);
    if (has) begin
      fork
        capture(len, w, gap, sl, terr);
        begin
          if (chg >= 0) begin
            repeat (chg) @(negedge clk);
            status = 32'h0;
          end
        end
      join
      chk({nm, " reply word"}, w, ew);
      chk_rng({nm, " reply gap"}, gap, 2 * C - 3, 2 * C + 3);
      chk_rng({nm, " stop low"}, sl, 2 * C - 2, 2 * C + 2);
      chk({nm, " cell timing errors"}, terr, 0);
      k = 0;
      while (busy && k < 60) begin @(negedge clk); k++; end
      chk_rng({nm, " busy end after stop"}, k, C - 3, C + 3);
      chk({nm, " tx_active end"}, {31'b0, tx_active}, 32'h0);
    end else begin
      k = 0;
      while (busy && k < 10) begin @(negedge clk); k++; end
      chk_rng({nm, " busy drop"}, k, 0, 3);
      repeat (150) @(negedge clk);
      chk({nm, " no drive"}, dev_low - d0, 0);
    end
    chk({nm, " cmd_valid count"}, vld_cnt - v0, 1);
    chk({nm, " cmd"}, {24'h0, last_cmd}, {24'h0, c});
    repeat (20) @(negedge clk);
  endtask

  vec_t        tbl [4];
  logic        m_has;
  int          m_len, k, v0, d0;
  logic [31:0] m_w, rs;
  logic [7:0]  rc;

  initial begin
    tbl[0] = '{8'h01, 32'hA5F0_0F3C, 1'b1, 32, 32'hA5F0_0F3C};
    tbl[1] = '{8'h00, 32'h1234_5678, 1'b1, 24, 32'h0005_0002};
    tbl[2] = '{8'h40, 32'hFFFF_FFFF, 1'b0, 0,  32'h0};
    tbl[3] = '{8'h02, 32'h8000_0001, 1'b0, 0,  32'h0};

    rst_n = 1'b0; host_drv = 1'b0; status = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset cmd", {24'h0, cmd}, 32'h0);
    chk("reset cmd_valid", {31'b0, cmd_valid}, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset tx_active", {31'b0, tx_active}, 32'h0);
    chk("reset JB released", {31'b0, JB}, 32'h1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++)
      do_txn($sformatf("vec%0d", i), tbl[i].c, tbl[i].st, tbl[i].has, tbl[i].len, tbl[i].w, -1);

    // Status cleared about 16 cells into the reply; the wire must keep the latched value.
    do_txn("midway", 8'h01, 32'hC3C3_9696, 1'b1, 32, 32'hC3C3_9696, 2 * C + 16 * 4 * C);

    for (int i = 0; i < 3; i++) begin
      case ($urandom_range(0, 3))
        0:       rc = 8'h00;
        1:       rc = 8'h01;
        default: rc = 8'($urandom_range(0, 255));
      endcase
      rs = $urandom;
      model(rc, rs, m_has, m_len, m_w);
      do_txn($sformatf("rand%0d", i), rc, rs, m_has, m_len, m_w, -1);
    end

    // Abandoned command: three bits, then the host goes quiet for 10 us.
    v0 = vld_cnt; d0 = dev_low;
    @(negedge clk);
    host_bits(8'h01, 3);
    repeat (100) @(negedge clk);
    chk("timeout busy held", {31'b0, busy}, 32'h1);
    repeat (100) @(negedge clk);
    chk("timeout busy dropped", {31'b0, busy}, 32'h0);
    repeat (50) @(negedge clk);
    chk("timeout no cmd_valid", vld_cnt - v0, 0);
    chk("timeout no drive", dev_low - d0, 0);
    do_txn("after timeout", 8'h01, 32'h0F1E_2D3C, 1'b1, 32, 32'h0F1E_2D3C, -1);

    // Reset 1 us into a reply whose first bit is a 0 (line still held low).
    status = 32'h5A5A_5A5A;
    send_cmd(8'h01);
    k = 0;
    #1;
    while (JB !== 1'b0 && k < 300) begin @(negedge clk); k++; end
    repeat (C) @(negedge clk);
    chk("reply driving before reset", {31'b0, JB}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid-reply reset JB released", {31'b0, JB}, 32'h1);
    chk("mid-reply reset busy", {31'b0, busy}, 32'h0);
    chk("mid-reply reset tx_active", {31'b0, tx_active}, 32'h0);
    chk("mid-reply reset cmd", {24'h0, cmd}, 32'h0);
    chk("mid-reply reset cmd_valid", {31'b0, cmd_valid}, 32'h0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rs = $urandom;
    do_txn("after reset", 8'h01, rs, 1'b1, 32, rs, -1);

    chk("cmd_valid single-cycle", vld_long, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
